// File: rtl/spu_issue_pkg.sv
// Shared types and constants for the dual-issue hazard unit.
//   reg_idx_t     : architectural register index (NUM_REGS entries)
//   cnt_t         : scoreboard countdown (max producer latency 15)
//   issue_state_t : issue FSM states
//   FWD_WINDOW    : remaining count at/below which a result is on the forward network
//   BR_FLUSH_CYC  : cycles both ID/REG slots are flushed after a taken branch
package spu_issue_pkg;

    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned CNT_W    = 4;

    typedef logic [6:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        PAIR,
        ODD_ONLY,
        BFLUSH
    } issue_state_t;

    localparam cnt_t FWD_WINDOW   = cnt_t'(2);
    localparam cnt_t BR_FLUSH_CYC = cnt_t'(2);

    // Operand still too far from completion to be forwarded.
    function automatic logic src_raw(input logic use_op, input cnt_t c);
        return use_op && (c > FWD_WINDOW);
    endfunction

    // Operand in flight but close enough to take from the forward network.
    function automatic logic src_fwd(input logic use_op, input cnt_t c);
        return use_op && (c != '0) && (c <= FWD_WINDOW);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register latency scoreboard.
//   clk, reset          : clock, synchronous active-high reset (clears all counts)
//   load_even/odd       : slot issues a register write this cycle
//   rt_even/odd         : destination register of each slot
//   lat_even/odd        : producer latency loaded into the destination count
//   rd_addr[8]/rd_cnt[8]: read ports RA,RB,RC,RT of slot 1 then slot 2
module reg_scoreboard
    import spu_issue_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load_even,
    input  reg_idx_t rt_even,
    input  cnt_t     lat_even,
    input  logic     load_odd,
    input  reg_idx_t rt_odd,
    input  cnt_t     lat_odd,
    input  reg_idx_t rd_addr [8],
    output cnt_t     rd_cnt  [8]
);

    cnt_t cnt      [NUM_REGS];
    cnt_t cnt_next [NUM_REGS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_next[i] = (cnt[i] != '0) ? cnt[i] - cnt_t'(1) : '0;
            if (load_even && rt_even == reg_idx_t'(i))
                cnt_next[i] = lat_even;
            // Same-RT dual write keeps the longer of the two latencies.
            if (load_odd && rt_odd == reg_idx_t'(i))
                cnt_next[i] = (load_even && rt_even == rt_odd && lat_even > lat_odd)
                              ? lat_even : lat_odd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '{default: '0};
        else
            cnt <= cnt_next;
    end

    always_comb begin
        for (int unsigned k = 0; k < 8; k++)
            rd_cnt[k] = cnt[rd_addr[k]];
    end

endmodule

// File: rtl/issue_hazard_unit.sv
// Dual-issue hazard and scoreboard controller for the decode stage.
// Inputs : per-slot valid, regWriteEnable, RA/RB/RC/RT indices, use flags,
//          latency; branchTaken from the odd pipe; clk, reset (sync, active-high).
// Outputs: stallEven/stallOdd, flushEven/flushOdd, fetchHold and per-operand
//          selectForward controls, all combinational for same-cycle use.
module issue_hazard_unit
    import spu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ID1,
    input  logic             valid_ID2,
    input  logic             regWriteEnable_ID1,
    input  logic             regWriteEnable_ID2,
    input  logic [6:0]       readRegisterRA_ID1,
    input  logic [6:0]       readRegisterRB_ID1,
    input  logic [6:0]       readRegisterRC_ID1,
    input  logic [6:0]       readRegisterRT_ID1,
    input  logic [6:0]       readRegisterRA_ID2,
    input  logic [6:0]       readRegisterRB_ID2,
    input  logic [6:0]       readRegisterRC_ID2,
    input  logic [6:0]       readRegisterRT_ID2,
    input  logic             useRA_ID1,
    input  logic             useRB_ID1,
    input  logic             useRC_ID1,
    input  logic             useRA_ID2,
    input  logic             useRB_ID2,
    input  logic             useRC_ID2,
    input  logic [CNT_W-1:0] latency_ID1,
    input  logic [CNT_W-1:0] latency_ID2,
    input  logic             branchTaken,
    output logic             stallEven,
    output logic             stallOdd,
    output logic             flushEven,
    output logic             flushOdd,
    output logic             fetchHold,
    output logic             selectForwardRA_ID1,
    output logic             selectForwardRB_ID1,
    output logic             selectForwardRC_ID1,
    output logic             selectForwardRA_ID2,
    output logic             selectForwardRB_ID2,
    output logic             selectForwardRC_ID2
);

    issue_state_t state, state_next;
    cnt_t         fcnt, fcnt_next;
    logic         load_even, load_odd;
    reg_idx_t     rd_addr [8];
    cnt_t         rd_cnt  [8];

    assign rd_addr[0] = readRegisterRA_ID1;
    assign rd_addr[1] = readRegisterRB_ID1;
    assign rd_addr[2] = readRegisterRC_ID1;
    assign rd_addr[3] = readRegisterRT_ID1;
    assign rd_addr[4] = readRegisterRA_ID2;
    assign rd_addr[5] = readRegisterRB_ID2;
    assign rd_addr[6] = readRegisterRC_ID2;
    assign rd_addr[7] = readRegisterRT_ID2;

    reg_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .load_even (load_even),
        .rt_even   (readRegisterRT_ID1),
        .lat_even  (latency_ID1),
        .load_odd  (load_odd),
        .rt_odd    (readRegisterRT_ID2),
        .lat_odd   (latency_ID2),
        .rd_addr   (rd_addr),
        .rd_cnt    (rd_cnt)
    );

    logic       haz_even, haz_odd, intra;
    logic [2:0] fwd_even, fwd_odd;

    always_comb begin
        haz_even = valid_ID1 && (src_raw(useRA_ID1, rd_cnt[0]) || src_raw(useRB_ID1, rd_cnt[1]) ||
                                 src_raw(useRC_ID1, rd_cnt[2]) ||
                                 (regWriteEnable_ID1 && rd_cnt[3] > latency_ID1));
        haz_odd  = valid_ID2 && (src_raw(useRA_ID2, rd_cnt[4]) || src_raw(useRB_ID2, rd_cnt[5]) ||
                                 src_raw(useRC_ID2, rd_cnt[6]) ||
                                 (regWriteEnable_ID2 && rd_cnt[7] > latency_ID2));
        // Dependencies on the even instruction of the same pair; only meaningful in PAIR.
        intra    = valid_ID1 && regWriteEnable_ID1 && valid_ID2 &&
                   ((useRA_ID2 && readRegisterRA_ID2 == readRegisterRT_ID1) ||
                    (useRB_ID2 && readRegisterRB_ID2 == readRegisterRT_ID1) ||
                    (useRC_ID2 && readRegisterRC_ID2 == readRegisterRT_ID1) ||
                    (regWriteEnable_ID2 && readRegisterRT_ID2 == readRegisterRT_ID1 &&
                     latency_ID2 < latency_ID1));
        fwd_even = {3{valid_ID1}} & {src_fwd(useRC_ID1, rd_cnt[2]), src_fwd(useRB_ID1, rd_cnt[1]),
                                     src_fwd(useRA_ID1, rd_cnt[0])};
        fwd_odd  = {3{valid_ID2}} & {src_fwd(useRC_ID2, rd_cnt[6]), src_fwd(useRB_ID2, rd_cnt[5]),
                                     src_fwd(useRA_ID2, rd_cnt[4])};
    end

    logic [2:0] sel_even, sel_odd;

    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        load_even  = 1'b0;
        load_odd   = 1'b0;
        stallEven  = 1'b0;
        stallOdd   = 1'b0;
        flushEven  = 1'b0;
        flushOdd   = 1'b0;
        fetchHold  = 1'b0;
        sel_even   = '0;
        sel_odd    = '0;

        unique case (state)
            PAIR: begin
                sel_even = fwd_even;
                sel_odd  = fwd_odd;
                if (haz_even) begin
                    stallEven = 1'b1;
                    stallOdd  = 1'b1;
                    fetchHold = 1'b1;
                end else if (haz_odd || intra) begin
                    load_even  = valid_ID1 && regWriteEnable_ID1;
                    stallOdd   = 1'b1;
                    fetchHold  = 1'b1;
                    state_next = ODD_ONLY;
                end else begin
                    load_even = valid_ID1 && regWriteEnable_ID1;
                    load_odd  = valid_ID2 && regWriteEnable_ID2;
                end
            end
            ODD_ONLY: begin
                flushEven = 1'b1;
                sel_odd   = fwd_odd;
                if (haz_odd) begin
                    stallOdd  = 1'b1;
                    fetchHold = 1'b1;
                end else begin
                    load_odd   = valid_ID2 && regWriteEnable_ID2;
                    state_next = PAIR;
                end
            end
            BFLUSH: begin
                flushEven = 1'b1;
                flushOdd  = 1'b1;
                fcnt_next = fcnt - cnt_t'(1);
                if (fcnt <= cnt_t'(1))
                    state_next = PAIR;
            end
            default: state_next = PAIR;
        endcase

        // A taken branch discards the current pair regardless of hazards.
        if (branchTaken) begin
            stallEven  = 1'b0;
            stallOdd   = 1'b0;
            fetchHold  = 1'b0;
            load_even  = 1'b0;
            load_odd   = 1'b0;
            state_next = BFLUSH;
            fcnt_next  = BR_FLUSH_CYC;
        end

        if (reset) begin
            stallEven = 1'b0;
            stallOdd  = 1'b0;
            flushEven = 1'b0;
            flushOdd  = 1'b0;
            fetchHold = 1'b0;
            load_even = 1'b0;
            load_odd  = 1'b0;
            sel_even  = '0;
            sel_odd   = '0;
        end
    end

    assign {selectForwardRC_ID1, selectForwardRB_ID1, selectForwardRA_ID1} = sel_even;
    assign {selectForwardRC_ID2, selectForwardRB_ID2, selectForwardRA_ID2} = sel_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAIR;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

endmodule
